// File: rtl/alu_share_ctrl_pkg.sv
// Shared definitions for the ALU-sharing controller:
// ALU op codes and the controller FSM state encoding.
package alu_ctrl_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_MUL = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_SLT = 3'b101;
  localparam logic [2:0] OP_NOP = 3'b111;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_R,
    WAIT_Z,
    RESP
  } state_t;

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Requester/response bundle of the ALU-sharing controller.
// master: requester side (drives req_*, resp_ready); slave: controller side.
interface alu_share_ctrl_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
);

  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [32*N_REQ-1:0] req_a;
  logic [32*N_REQ-1:0] req_b;
  logic [3*N_REQ-1:0]  req_op;
  logic                resp_valid;
  logic                resp_ready;
  logic [ID_W-1:0]     resp_id;
  logic [31:0]         resp_r;
  logic                resp_zf;

  modport master (
    output req_valid, req_a, req_b, req_op,
    output resp_ready,
    input  req_ready,
    input  resp_valid, resp_id, resp_r, resp_zf
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op,
    input  resp_ready,
    output req_ready,
    output resp_valid, resp_id, resp_r, resp_zf
  );

endinterface

// File: rtl/alu_share_ctrl_alu.sv
// Registered 32-bit ALU: r one clock after operands, zf one clock after r.
// Ports: clk, rst, a, b, sel in; r, zf out. Unknown sel yields r=0.
module alu32
  import alu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  sel,
  output logic [31:0] r,
  output logic        zf
);

  logic [31:0] f;

  always_comb begin
    f = '0;
    unique case (1'b1)
      (sel == OP_ADD): f = a + b;
      (sel == OP_AND): f = a & b;
      (sel == OP_OR):  f = a | b;
      (sel == OP_MUL): f = a * b;
      (sel == OP_SUB): f = a - b;
      (sel == OP_SLT): f = {31'd0, a < b};
      default:         f = '0;
    endcase
  end

  // zf is derived from the registered r, so it lags r by one clock
  always_ff @(posedge clk) begin
    if (rst) begin
      r  <= '0;
      zf <= 1'b1;
    end else begin
      r  <= f;
      zf <= (r == '0);
    end
  end

endmodule

// File: rtl/alu_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter; search starts at ptr.
// Ports: clk, rst, req, ptr in; one-hot gnt and its index gnt_idx out.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int PW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_idx
);

  // walk from farthest to nearest so the one closest to ptr wins
  always_comb begin
    int k;
    k       = 0;
    gnt     = '0;
    gnt_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      k = int'(ptr) + i;
      if (k >= N) k = k - N;
      if (req[k]) begin
        gnt     = '0;
        gnt[k]  = 1'b1;
        gnt_idx = PW'(k);
      end
    end
  end

  a_onehot: assert property (
    @(posedge clk) disable iff (rst) $onehot0(gnt)
  );

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one registered ALU between N_REQ requesters, round-robin.
// Ports: clk, rst, bus (slave), alu_a/alu_b/alu_sel out, alu_r/alu_zf in, busy.
module alu_share_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int ID_W    = 2,
  parameter int ALU_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  alu_share_ctrl_if.slave       bus,
  output logic [31:0]           alu_a,
  output logic [31:0]           alu_b,
  output logic [2:0]            alu_sel,
  input  logic [31:0]           alu_r,
  input  logic                  alu_zf,
  output logic                  busy
);

  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(ALU_LAT + 1);

  state_t          state;
  state_t          nstate;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   gnt_idx;
  logic [N_REQ-1:0] gnt;
  logic [N_REQ-1:0] rdy;
  logic [CW-1:0]   cnt;
  logic [31:0]     sel_a;
  logic [31:0]     sel_b;
  logic [2:0]      sel_op;
  logic            vld_q;
  logic [ID_W-1:0] id_q;
  logic [31:0]     r_q;
  logic            zf_q;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (bus.req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    sel_a  = bus.req_a[32*gnt_idx +: 32];
    sel_b  = bus.req_b[32*gnt_idx +: 32];
    sel_op = bus.req_op[3*gnt_idx +: 3];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:    if (|gnt) nstate = WAIT_R;
      WAIT_R:  if (cnt == '0) nstate = WAIT_Z;
      WAIT_Z:  nstate = RESP;
      RESP:    if (bus.resp_ready) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // grant is only offered while idle and out of reset
  always_comb begin
    rdy  = '0;
    busy = 1'b1;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (!rst) rdy = gnt;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr  <= '0;
      cnt     <= '0;
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sel <= OP_NOP;
      vld_q   <= 1'b0;
      id_q    <= '0;
      r_q     <= '0;
      zf_q    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (|gnt) begin
          alu_a   <= sel_a;
          alu_b   <= sel_b;
          alu_sel <= sel_op;
          id_q    <= ID_W'(gnt_idx);
          cnt     <= CW'(ALU_LAT);
          rr_ptr  <= (gnt_idx == PW'(N_REQ - 1)) ?
                     '0 : gnt_idx + PW'(1);
        end
        // r appears ALU_LAT clocks after the operands
        WAIT_R: begin
          if (cnt == '0) r_q <= alu_r;
          else           cnt <= cnt - CW'(1);
        end
        WAIT_Z: begin
          zf_q    <= alu_zf;
          vld_q   <= 1'b1;
          alu_sel <= OP_NOP;
        end
        RESP: if (bus.resp_ready) vld_q <= 1'b0;
        default: ;
      endcase
    end
  end

  assign bus.req_ready  = rdy;
  assign bus.resp_valid = vld_q;
  assign bus.resp_id    = id_q;
  assign bus.resp_r     = r_q;
  assign bus.resp_zf    = zf_q;

endmodule
